// File: rtl/wb_commit_pkg.sv
// Shared types for the writeback commit stage: widths, per-channel control layout, FSM states.
// Optional difftest commit ports are controlled by WB_COMMIT_DIFFTEST_EN.
package wb_commit_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;
  localparam int unsigned REG_AW       = 5;

  // Control half of a MEM-to-WB channel; pc/wdata are XLEN-sized and kept beside it.
  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] waddr;
  } wb_ctl_t;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StDrain = 1'b1
  } wb_state_e;

  function automatic int unsigned ptr_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_commit_pick.sv
// Finds the next set channel-valid bit strictly above ptr_i; last_o when none remains.
module wb_commit_pick import wb_commit_pkg::*; #(
  parameter int unsigned NCH = 2,
  parameter int unsigned PW  = 1
) (
  input  logic [NCH-1:0] ch_v_i,
  input  logic [PW-1:0]  ptr_i,
  output logic [PW-1:0]  nxt_o,
  output logic           last_o
);

  always_comb begin
    nxt_o  = '0;
    last_o = 1'b1;
    // Walk downwards so the lowest qualifying index is the one left standing.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_v_i[i] && (i > int'(ptr_i))) begin
        nxt_o  = PW'(i);
        last_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback commit: one holding entry, retires channels to NPORT register-file write ports.
// Define WB_COMMIT_DIFFTEST_EN to expose commit_valid/commit_pc.
module wb_commit import wb_commit_pkg::*; #(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned NCH   = 2,
  parameter int unsigned NPORT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NCH-1:0]          in_ch_v,
  input  logic [NCH*XLEN-1:0]     in_pc,
  input  logic [NCH-1:0]          in_we,
  input  logic [NCH*REG_AW-1:0]   in_waddr,
  input  logic [NCH*XLEN-1:0]     in_wdata,
  input  logic                    stall,
  output logic [NPORT-1:0]        rf_we,
  output logic [NPORT*REG_AW-1:0] rf_waddr,
  output logic [NPORT*XLEN-1:0]   rf_wdata,
  output logic [63:0]             retire_cnt
`ifdef WB_COMMIT_DIFFTEST_EN
  ,
  output logic [NCH-1:0]          commit_valid,
  output logic [NCH*XLEN-1:0]     commit_pc
`endif
);

  localparam int unsigned PW = ptr_w(NCH);

  wb_state_e                     state_q, state_d;
  logic [PW-1:0]                 ptr_q, ptr_d;
  logic [NCH-1:0]                ch_v_q, ch_v_d;
  wb_ctl_t [NCH-1:0]             ctl_q, ctl_d;
  logic [NCH-1:0][XLEN-1:0]      data_q, data_d;
  logic [63:0]                   retire_cnt_q, retire_cnt_d;

  logic           hold_v, active, last, done, accept;
  logic [NCH-1:0] retire;
  logic [PW-1:0]  nxt_ptr, first_ptr;

  assign hold_v   = (state_q == StDrain);
  // rst gates retirement so a reset mid-drain emits nothing further.
  assign active   = hold_v && !stall && !rst;
  assign done     = active && last;
  assign in_ready = !rst && (!hold_v || done);
  assign accept   = in_valid && in_ready;

  if (NPORT == 1) begin : g_seq
    logic [PW-1:0] held_nxt, in_nxt;
    logic          held_last, unused_in_last;

    wb_commit_pick #(.NCH(NCH), .PW(PW)) u_pick_held (
      .ch_v_i (ch_v_q),
      .ptr_i  (ptr_q),
      .nxt_o  (held_nxt),
      .last_o (held_last)
    );

    wb_commit_pick #(.NCH(NCH), .PW(PW)) u_pick_in (
      .ch_v_i (in_ch_v),
      .ptr_i  ('0),
      .nxt_o  (in_nxt),
      .last_o (unused_in_last)
    );

    always_comb begin
      retire    = '0;
      last      = held_last;
      nxt_ptr   = held_nxt;
      first_ptr = in_ch_v[0] ? '0 : in_nxt;
      rf_we     = '0;
      rf_waddr  = '0;
      rf_wdata  = '0;
      // ptr only rests on an invalid channel when the whole entry is empty.
      if (active) retire[ptr_q] = ch_v_q[ptr_q];
      if (retire[ptr_q] && ctl_q[ptr_q].we && (ctl_q[ptr_q].waddr != '0)) begin
        rf_we[0]           = 1'b1;
        rf_waddr[REG_AW-1:0] = ctl_q[ptr_q].waddr;
        rf_wdata[XLEN-1:0] = data_q[ptr_q];
      end
    end
  end else begin : g_par
    logic [NCH-1:0] wr_raw, kill;

    always_comb begin
      retire    = active ? ch_v_q : '0;
      last      = 1'b1;
      nxt_ptr   = '0;
      first_ptr = '0;
      wr_raw    = '0;
      kill      = '0;
      rf_we     = '0;
      rf_waddr  = '0;
      rf_wdata  = '0;
      for (int i = 0; i < NCH; i++) begin
        wr_raw[i] = retire[i] && ctl_q[i].we && (ctl_q[i].waddr != '0);
      end
      // Same destination in one entry: the younger (higher) channel wins.
      for (int i = 0; i < NCH; i++) begin
        for (int j = i + 1; j < NCH; j++) begin
          if (wr_raw[i] && wr_raw[j] && (ctl_q[j].waddr == ctl_q[i].waddr)) kill[i] = 1'b1;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (wr_raw[i] && !kill[i]) begin
          rf_we[i]                     = 1'b1;
          rf_waddr[i*REG_AW +: REG_AW] = ctl_q[i].waddr;
          rf_wdata[i*XLEN +: XLEN]     = data_q[i];
        end
      end
    end
  end

`ifdef WB_COMMIT_DIFFTEST_EN
  logic [NCH-1:0][XLEN-1:0] pc_q, pc_d;

  always_comb begin
    pc_d         = pc_q;
    commit_valid = retire;
    commit_pc    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (accept) pc_d[i] = in_pc[i*XLEN +: XLEN];
      if (retire[i]) commit_pc[i*XLEN +: XLEN] = pc_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end
`else
  logic unused_pc;
  assign unused_pc = ^in_pc;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ch_v_d       = ch_v_q;
    ctl_d        = ctl_q;
    data_d       = data_q;
    retire_cnt_d = retire_cnt_q + 64'($countones(retire));
    if (active) ptr_d = last ? '0 : nxt_ptr;
    if (done) state_d = StIdle;
    if (accept) begin
      state_d = StDrain;
      ptr_d   = first_ptr;
      ch_v_d  = in_ch_v;
      for (int i = 0; i < NCH; i++) begin
        ctl_d[i].we    = in_we[i];
        ctl_d[i].waddr = in_waddr[i*REG_AW +: REG_AW];
        data_d[i]      = in_wdata[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      ch_v_q       <= '0;
      ctl_q        <= '0;
      data_q       <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ch_v_q       <= ch_v_d;
      ctl_q        <= ctl_d;
      data_q       <= data_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: a parallel-port (NPORT=2) and a sequential (NPORT=1) instance on shared inputs.
module tb_wb_commit;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         stall = 1'b0;
  logic [1:0]   in_ch_v = '0, in_we = '0;
  logic [127:0] in_pc = '0, in_wdata = '0;
  logic [9:0]   in_waddr = '0;

  logic         d_ready, s_ready;
  logic [1:0]   d_we;
  logic [0:0]   s_we;
  logic [9:0]   d_waddr;
  logic [4:0]   s_waddr;
  logic [127:0] d_wdata;
  logic [63:0]  s_wdata, d_cnt, s_cnt;
`ifdef WB_COMMIT_DIFFTEST_EN
  logic [1:0]   d_cv, s_cv;
  logic [127:0] d_cpc, s_cpc;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wb_commit #(.XLEN(64), .NCH(2), .NPORT(2)) u_dual (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_ready), .in_ch_v(in_ch_v),
    .in_pc(in_pc), .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata), .stall(stall),
    .rf_we(d_we), .rf_waddr(d_waddr), .rf_wdata(d_wdata), .retire_cnt(d_cnt)
`ifdef WB_COMMIT_DIFFTEST_EN
    , .commit_valid(d_cv), .commit_pc(d_cpc)
`endif
  );

  wb_commit #(.XLEN(64), .NCH(2), .NPORT(1)) u_seq (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_ready), .in_ch_v(in_ch_v),
    .in_pc(in_pc), .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata), .stall(stall),
    .rf_we(s_we), .rf_waddr(s_waddr), .rf_wdata(s_wdata), .retire_cnt(s_cnt)
`ifdef WB_COMMIT_DIFFTEST_EN
    , .commit_valid(s_cv), .commit_pc(s_cpc)
`endif
  );

  typedef struct packed {
    logic [1:0]  ch_v, we;
    logic [4:0]  a0, a1;
    logic [63:0] d0, d1;
    logic [1:0]  e_we;
    logic [4:0]  e_a0, e_a1;
    logic [63:0] e_d0, e_d1, e_cnt;
    logic        e_sready;
  } vec_t;

  // One cycle of expected port activity; the sequential model uses port 0 only.
  typedef struct packed {
    logic [1:0]   we;
    logic [9:0]   addr;
    logic [127:0] data;
    logic [1:0]   cv;
    logic [127:0] pc;
    logic [1:0]   n;
  } slot_t;

  slot_t dq[$], sq[$];
  logic [63:0] d_cnt_m, s_cnt_m;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic set_beat(input logic [1:0] cv, input logic [1:0] we, input logic [4:0] a0,
                          input logic [4:0] a1, input logic [63:0] d0, input logic [63:0] d1);
    in_ch_v = cv; in_we = we; in_waddr = {a1, a0}; in_wdata = {d1, d0};
    in_pc = {64'h8000_1004, 64'h8000_1000};
  endtask

  function automatic logic wr_ok(input int i);
    return in_ch_v[i] && in_we[i] && (in_waddr[i*5 +: 5] != 5'd0);
  endfunction

  function automatic slot_t mk_dual();
    slot_t s;
    logic [1:0] wr;
    s = '0;
    wr = {wr_ok(1), wr_ok(0)};
    if (wr[0] && wr[1] && in_waddr[4:0] == in_waddr[9:5]) wr[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (wr[i]) begin
        s.we[i] = 1'b1;
        s.addr[i*5 +: 5] = in_waddr[i*5 +: 5];
        s.data[i*64 +: 64] = in_wdata[i*64 +: 64];
      end
      if (in_ch_v[i]) s.pc[i*64 +: 64] = in_pc[i*64 +: 64];
    end
    s.cv = in_ch_v;
    s.n = 2'(in_ch_v[0]) + 2'(in_ch_v[1]);
    return s;
  endfunction

  task automatic push_seq();
    slot_t s;
    int cnt;
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      if (in_ch_v[i]) begin
        s = '0;
        if (wr_ok(i)) begin
          s.we[0] = 1'b1;
          s.addr[4:0] = in_waddr[i*5 +: 5];
          s.data[63:0] = in_wdata[i*64 +: 64];
        end
        s.cv[i] = 1'b1;
        s.pc[i*64 +: 64] = in_pc[i*64 +: 64];
        s.n = 2'd1;
        sq.push_back(s);
        cnt++;
      end
    end
    if (cnt == 0) sq.push_back('0);
  endtask

  vec_t vt[8];

  initial begin
    slot_t de, se;
    logic dh, sh, dr, sr;

    vt[0] = '{2'b11, 2'b11, 5'd5, 5'd6, 64'hA, 64'hB,
              2'b11, 5'd5, 5'd6, 64'hA, 64'hB, 64'd2, 1'b0};
    vt[1] = '{2'b11, 2'b11, 5'd7, 5'd7, 64'h1, 64'h2,
              2'b10, 5'd0, 5'd7, 64'h0, 64'h2, 64'd2, 1'b0};
    vt[2] = '{2'b01, 2'b01, 5'd0, 5'd9, 64'h33, 64'h44,
              2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 64'd1, 1'b1};
    vt[3] = '{2'b00, 2'b11, 5'd4, 5'd5, 64'h1, 64'h2,
              2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 64'd0, 1'b1};
    vt[4] = '{2'b10, 2'b10, 5'd12, 5'd9, 64'h77, 64'h55,
              2'b10, 5'd0, 5'd9, 64'h0, 64'h55, 64'd1, 1'b1};
    vt[5] = '{2'b11, 2'b01, 5'd3, 5'd3, 64'hC, 64'hD,
              2'b01, 5'd3, 5'd0, 64'hC, 64'h0, 64'd2, 1'b0};
    vt[6] = '{2'b11, 2'b11, 5'd0, 5'd0, 64'hE, 64'hF,
              2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 64'd2, 1'b0};
    vt[7] = '{2'b01, 2'b11, 5'd31, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
              2'b01, 5'd31, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'd1, 1'b1};

    // Single-beat vectors: parallel instance outputs one cycle after acceptance.
    for (int k = 0; k < 8; k++) begin
      do_reset();
      @(negedge clk);
      chk($sformatf("vec%0d_rst_dready", k), 128'(d_ready), 128'd1);
      chk($sformatf("vec%0d_rst_dwe", k), 128'(d_we), 128'd0);
      set_beat(vt[k].ch_v, vt[k].we, vt[k].a0, vt[k].a1, vt[k].d0, vt[k].d1);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_we", k), 128'(d_we), 128'(vt[k].e_we));
      chk($sformatf("vec%0d_waddr", k), 128'(d_waddr), 128'({vt[k].e_a1, vt[k].e_a0}));
      chk($sformatf("vec%0d_wdata", k), d_wdata, {vt[k].e_d1, vt[k].e_d0});
      chk($sformatf("vec%0d_sready", k), 128'(s_ready), 128'(vt[k].e_sready));
      tick();
      @(negedge clk);
      chk($sformatf("vec%0d_cnt", k), 128'(d_cnt), 128'(vt[k].e_cnt));
      chk($sformatf("vec%0d_idle_we", k), 128'(d_we), 128'd0);
    end

    // Sequential drain with a 3-cycle stall between the two channels.
    do_reset();
    set_beat(2'b11, 2'b11, 5'd5, 5'd6, 64'hA, 64'hB);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("seq_c1_we", 128'(s_we), 128'd1);
    chk("seq_c1_waddr", 128'(s_waddr), 128'd5);
    chk("seq_c1_wdata", 128'(s_wdata), 128'hA);
    chk("seq_c1_ready", 128'(s_ready), 128'd0);
    tick();
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_we", c), 128'(s_we), 128'd0);
      chk($sformatf("stall%0d_waddr", c), 128'(s_waddr), 128'd0);
      chk($sformatf("stall%0d_ready", c), 128'(s_ready), 128'd0);
      chk($sformatf("stall%0d_cnt", c), 128'(s_cnt), 128'd1);
      tick();
    end
    stall = 1'b0;
    @(negedge clk);
    chk("seq_c2_we", 128'(s_we), 128'd1);
    chk("seq_c2_waddr", 128'(s_waddr), 128'd6);
    chk("seq_c2_wdata", 128'(s_wdata), 128'hB);
    chk("seq_c2_ready", 128'(s_ready), 128'd1);
    tick();
    @(negedge clk);
    chk("seq_cnt", 128'(s_cnt), 128'd2);

    // Reset in the middle of a drain drops the second channel.
    do_reset();
    set_beat(2'b11, 2'b11, 5'd5, 5'd6, 64'hA, 64'hB);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_c1_waddr", 128'(s_waddr), 128'd5);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_in_rst_we", 128'(s_we), 128'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_after_we", 128'(s_we), 128'd0);
    chk("rstmid_after_cnt", 128'(s_cnt), 128'd0);
    chk("rstmid_after_ready", 128'(s_ready), 128'd1);
    tick();
    @(negedge clk);
    chk("rstmid_later_we", 128'(s_we), 128'd0);

    // retire_cnt wrap: preset just below 2^64, then retire 2 and 1.
    do_reset();
    force u_dual.retire_cnt_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release u_dual.retire_cnt_q;
    set_beat(2'b11, 2'b00, 5'd1, 5'd2, 64'h0, 64'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_preset", 128'(d_cnt), 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE);
    tick();
    @(negedge clk);
    chk("wrap_zero", 128'(d_cnt), 128'd0);
    set_beat(2'b01, 2'b00, 5'd1, 5'd2, 64'h0, 64'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("wrap_one", 128'(d_cnt), 128'd1);

    // Random traffic against queue-of-slots reference models.
    do_reset();
    dq.delete(); sq.delete();
    d_cnt_m = '0; s_cnt_m = '0;
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 4) == 0);
      in_ch_v = 2'($urandom_range(0, 3));
      in_we = 2'($urandom_range(0, 3));
      in_waddr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      in_wdata = {$urandom, $urandom, $urandom, $urandom};
      in_pc = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      dh = (dq.size() > 0);
      sh = (sq.size() > 0);
      dr = !dh || (!stall && dq.size() == 1);
      sr = !sh || (!stall && sq.size() == 1);
      de = (dh && !stall) ? dq[0] : '0;
      se = (sh && !stall) ? sq[0] : '0;
      chk("rnd_d_ready", 128'(d_ready), 128'(dr));
      chk("rnd_d_we", 128'(d_we), 128'(de.we));
      chk("rnd_d_waddr", 128'(d_waddr), 128'(de.addr));
      chk("rnd_d_wdata", d_wdata, de.data);
      chk("rnd_d_cnt", 128'(d_cnt), 128'(d_cnt_m));
      chk("rnd_s_ready", 128'(s_ready), 128'(sr));
      chk("rnd_s_we", 128'(s_we), 128'(se.we[0]));
      chk("rnd_s_waddr", 128'(s_waddr), 128'(se.addr[4:0]));
      chk("rnd_s_wdata", 128'(s_wdata), 128'(se.data[63:0]));
      chk("rnd_s_cnt", 128'(s_cnt), 128'(s_cnt_m));
`ifdef WB_COMMIT_DIFFTEST_EN
      chk("rnd_d_cv", 128'(d_cv), 128'(de.cv));
      chk("rnd_d_cpc", d_cpc, de.pc);
      chk("rnd_s_cv", 128'(s_cv), 128'(se.cv));
      chk("rnd_s_cpc", s_cpc, se.pc);
`endif
      if (dh && !stall) begin
        d_cnt_m = d_cnt_m + 64'(dq[0].n);
        void'(dq.pop_front());
      end
      if (sh && !stall) begin
        s_cnt_m = s_cnt_m + 64'(sq[0].n);
        void'(sq.pop_front());
      end
      if (in_valid && dr) dq.push_back(mk_dual());
      if (in_valid && sr) push_seq();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 Parameter XLEN, default 64, datapath width.
REQ-002 Parameter NCH, default 2, instruction channels per input beat (1..2).
REQ-003 Parameter NPORT, default 1, register-file write ports; legal values 1 or NCH.
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  MEM beat valid.
REQ-007 in_ready  out  1  wb_commit accepts a beat this cycle.
REQ-008 in_ch_v  in  NCH  per-channel instruction valid.
REQ-009 in_pc  in  NCH*XLEN  per-channel PC.
REQ-010 in_we  in  NCH  per-channel register write enable.
REQ-011 in_waddr  in  NCH*5  per-channel destination register.
REQ-012 in_wdata  in  NCH*XLEN  per-channel write data.
REQ-013 stall  in  1  freeze retirement (trap/debug hold).
REQ-014 rf_we  out  NPORT  register-file write enable per port.
REQ-015 rf_waddr  out  NPORT*5  write address per port.
REQ-016 rf_wdata  out  NPORT*XLEN  write data per port.
REQ-017 retire_cnt  out  64  retired-instruction count.

Function
REQ-018 Beat accepted when in_valid && in_ready; captured into one holding entry (hold_v plus all channel fields).
REQ-019 in_ready = !hold_v || (!stall && entry completes this cycle); back-to-back beats at full rate SHALL be sustained.
REQ-020 rf outputs SHALL be driven combinationally from the holding entry; write latency is one cycle after acceptance.
REQ-021 NPORT==NCH: all valid channels of the entry retire in one non-stalled cycle, channel i on port i.
REQ-022 NPORT==NCH, two channels writing same nonzero waddr in one entry: higher channel index wins, lower channel's rf_we forced 0 (both still retire).
REQ-023 NPORT==1: FSM IDLE (hold_v=0) / DRAIN (hold_v=1, ptr = next channel); each non-stalled DRAIN cycle emits channel ptr on port 0, advances ptr to next set in_ch_v bit; entry completes on last valid channel.
REQ-024 Channels with in_ch_v=0 SHALL be skipped with zero cycle cost; an entry with no valid channel completes in one cycle with no write and no retire.
REQ-025 Write with waddr==0: rf_we=0, instruction still retires.
REQ-026 Any port with rf_we=0 SHALL drive rf_waddr=0, rf_wdata=0.
REQ-027 stall=1: no rf write, no retire, entry and ptr held, in_ready=0 if hold_v.
REQ-028 retire_cnt increments by number of channels retired in the cycle; wraps modulo 2^64.

Reset
REQ-029 On rst: hold_v=0, ptr=0, FSM IDLE, retire_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, in_ready=1 the cycle after rst falls.
REQ-030 rst mid-DRAIN SHALL discard remaining channels with no further writes.

Configuration
REQ-031 Macro WB_COMMIT_DIFFTEST_EN defined: extra outputs commit_valid (NCH) and commit_pc (NCH*XLEN); commit_valid[i] pulses the cycle channel i retires, commit_pc[i] its PC, both 0 otherwise and on reset.
REQ-032 Macro undefined: commit ports absent; all other behaviour identical.

Structure
REQ-033 Shared package: XLEN default, register-address width 5, packed MEM-to-WB channel field layout, FSM state encoding.
REQ-034 One sub-module wb_commit_pick: combinational next-valid-channel finder (in_ch_v, ptr -> next ptr, last flag), used only when NPORT==1.

Verification
REQ-035 NCH=2,NPORT=2: beat ch_v=11, we=11, waddr={5,6}, data={0xA,0xB} -> next cycle rf_we=11, x5=0xA, x6=0xB, retire_cnt=2.
REQ-036 NCH=2,NPORT=1: same beat -> cycle1 port0 x5=0xA, cycle2 x6=0xB, in_ready=0 in cycle1, 1 in cycle2.
REQ-037 NPORT=2, waddr={7,7}, data={1,2} -> only port1 writes x7=2, retire_cnt +2.
REQ-038 Beat waddr=0 we=1 ch_v=01 -> rf_we=0, retire_cnt +1; beat ch_v=00 -> no write, count unchanged, 1 cycle.
REQ-039 NPORT=1, stall=1 for 3 cycles during DRAIN -> outputs frozen zero-write, then resume remaining channel; rst mid-DRAIN -> no pending write appears, retire_cnt=0.
REQ-040 retire_cnt preset near 0xFFFF_FFFF_FFFF_FFFF via 2-channel retires -> wraps to 0 then 1.
